// File: rtl/obi_slave_pipe_if.sv
// OBI A/R channel bundle between an interconnect master and obi_slave_pipe.
// Ports: req/gnt/addr/we/be/wdata/aid (A), rvalid/rready/rdata/err/rid (R).
interface obi_slave_pipe_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 1
);
  localparam int BYTES = DATA_WIDTH / 8;

  logic                  req;
  logic                  gnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  we;
  logic [BYTES-1:0]      be;
  logic [DATA_WIDTH-1:0] wdata;
  logic [ID_WIDTH-1:0]   aid;

  logic                  rvalid;
  logic                  rready;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  err;
  logic [ID_WIDTH-1:0]   rid;

  modport master (
    output req, addr, we, be, wdata, aid, rready,
    input  gnt, rvalid, rdata, err, rid
  );

  modport slave (
    input  req, addr, we, be, wdata, aid, rready,
    output gnt, rvalid, rdata, err, rid
  );
endinterface

// File: rtl/obi_slave_pipe.sv
// Pipelined OBI scratchpad SRAM slave: up to MAX_OUTSTANDING in flight, in-order.
// Ports: clk_i, reset_i (sync, active-high), obi (slave modport of obi_slave_pipe_if).
module obi_slave_pipe #(
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 32,
  parameter int          MEM_DEPTH_LOG2  = 6,
  parameter logic [63:0] BASE_ADDR       = 64'h0,
  parameter int          MAX_OUTSTANDING = 2,
  parameter int          ID_WIDTH        = 1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  obi_slave_pipe_if.slave  obi
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam int ADDR_LSB = $clog2(BYTES);
  localparam int DEPTH    = 1 << MEM_DEPTH_LOG2;
  localparam int HI_LSB   = ADDR_LSB + MEM_DEPTH_LOG2;
  localparam int CW       = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW       =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CW-1:0] MAX_C  = CW'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_P = PW'(MAX_OUTSTANDING - 1);
  localparam logic [ADDR_WIDTH-1:0] BASE =
    BASE_ADDR[ADDR_WIDTH-1:0];

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // ---------------- decode ----------------
  logic [ADDR_WIDTH-1:0]     offset;
  logic                      err_dec;
  logic [MEM_DEPTH_LOG2-1:0] idx;

  // BASE is window-aligned, so offset low bits equal addr low bits.
  always_comb begin
    offset  = obi.addr - BASE;
    err_dec = (offset[ADDR_WIDTH-1:HI_LSB] != '0)
            | (offset[ADDR_LSB-1:0] != '0);
    idx     = offset[ADDR_LSB +: MEM_DEPTH_LOG2];
  end

  // ---------------- handshake ----------------
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt;
  logic          accept;
  logic          retire;
  logic          rsp_valid;

  assign gnt    = (cnt_q < MAX_C);
  assign accept = obi.req & gnt;
  assign retire = rsp_valid & obi.rready;

  // ---------------- SRAM ----------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] sram_rdata_q;
  logic                  mem_we;
  logic                  mem_re;

  assign mem_we = accept & obi.we & ~err_dec & ~reset_i;
  assign mem_re = accept & ~obi.we & ~err_dec & ~reset_i;

  // Non-read accepts load zero so write/error responses carry rdata 0.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (obi.be[b]) begin
          mem_q[idx][8*b +: 8] <= obi.wdata[8*b +: 8];
        end
      end
    end
    if (mem_re) begin
      sram_rdata_q <= mem_q[idx];
    end else if (accept) begin
      sram_rdata_q <= '0;
    end
  end

  // ---------------- response stage ----------------
  logic                stage_valid_q, stage_valid_d;
  logic                stage_err_q, stage_err_d;
  logic [ID_WIDTH-1:0] stage_rid_q, stage_rid_d;

  // ---------------- response FIFO ----------------
  logic [DATA_WIDTH-1:0] f_data_q [MAX_OUTSTANDING];
  logic                  f_err_q  [MAX_OUTSTANDING];
  logic [ID_WIDTH-1:0]   f_rid_q  [MAX_OUTSTANDING];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic          fifo_nempty;
  logic          push;
  logic          pop;

  assign fifo_nempty = (fifo_cnt_q != '0);

  // The stage is the bypass path: it only reaches the bus directly
  // when nothing older is queued; otherwise (or if it stalls) it
  // moves into the FIFO so the bus view stays stable.
  assign pop  = retire & fifo_nempty;
  assign push = stage_valid_q & ~(retire & ~fifo_nempty);

  always_comb begin
    cnt_d = cnt_q;
    case ({accept, retire})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase

    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;

    stage_valid_d = accept;
    stage_err_d   = accept ? err_dec : stage_err_q;
    stage_rid_d   = accept ? obi.aid : stage_rid_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q         <= '0;
      fifo_cnt_q    <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      stage_valid_q <= 1'b0;
      stage_err_q   <= 1'b0;
      stage_rid_q   <= '0;
    end else begin
      cnt_q         <= cnt_d;
      fifo_cnt_q    <= fifo_cnt_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      stage_valid_q <= stage_valid_d;
      stage_err_q   <= stage_err_d;
      stage_rid_q   <= stage_rid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      f_data_q[wr_ptr_q] <= sram_rdata_q;
      f_err_q[wr_ptr_q]  <= stage_err_q;
      f_rid_q[wr_ptr_q]  <= stage_rid_q;
    end
  end

  // ---------------- R channel ----------------
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  rsp_err;
  logic [ID_WIDTH-1:0]   rsp_rid;

  always_comb begin
    rsp_valid = fifo_nempty | stage_valid_q;
    rsp_data  = '0;
    rsp_err   = 1'b0;
    rsp_rid   = '0;
    if (fifo_nempty) begin
      rsp_data = f_data_q[rd_ptr_q];
      rsp_err  = f_err_q[rd_ptr_q];
      rsp_rid  = f_rid_q[rd_ptr_q];
    end else if (stage_valid_q) begin
      rsp_data = sram_rdata_q;
      rsp_err  = stage_err_q;
      rsp_rid  = stage_rid_q;
    end
  end

  assign obi.gnt    = gnt;
  assign obi.rvalid = rsp_valid;
  assign obi.rdata  = rsp_data;
  assign obi.err    = rsp_err;
  assign obi.rid    = rsp_rid;

  // ---------------- invariants ----------------
  a_no_overflow: assert property (
    @(posedge clk_i) disable iff (reset_i)
    !(push && !pop && fifo_cnt_q == MAX_C)
  );

  a_cnt_match: assert property (
    @(posedge clk_i) disable iff (reset_i)
    cnt_q == fifo_cnt_q + CW'(stage_valid_q)
  );

endmodule
